robo_display_scan: RTL and testbench

- Parametrised, time-multiplexed N-digit 7-segment display controller for the robot-vacuum status panel.
- Successor to the single-digit combinational status display.
- Scans N_DIGITS common digits, shows one hex nibble per digit, and adds anti-ghosting guard time, frame-consistent input buffering, and a blinking error override.
- Sits between the robot control FSM (status nibbles, error flag) and the board's segment/digit pins.

---
 rtl/robo_disp_pkg.sv | 55 +++++
 rtl/robo_display_scan_seg7_decode.sv | 15 +
 rtl/robo_display_scan.sv | 178 +++++++++++++++++
 tb/tb_robo_display_scan.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_disp_pkg.sv
// Purpose: shared glyph constants, error-mode state type and hex-to-segment lookup for robo_display_scan.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
package robo_disp_pkg;

    // Segment words are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ERR   = SEG_E;

    typedef enum logic {
        NORMAL = 1'b0,
        ERROR  = 1'b1
    } disp_state_e;

    // Hex nibble to segment word.
    function automatic logic [6:0] seg_w(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/robo_display_scan_seg7_decode.sv
// Purpose: hex nibble plus blank flag to 7-segment word.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module seg7_decode
    import robo_disp_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins over the glyph so the caller can gate guard/off periods here.
    assign seg_o = blank_i ? SEG_BLANK : seg_w(val_i);

endmodule

// File: rtl/robo_display_scan.sv
// Purpose: N-digit multiplexed 7-seg scanner with guard time, per-frame input capture and blinking error override; optional DISP_DIM_EN adds a dim input (~25% duty).
// Latency: one registered cycle from slot counter/digit index/frame buffer to dig_n/seg.
// Backpressure: none; free-running scan, val_in sampled only at frame start (or continuously while en = 0).
module robo_display_scan
    import robo_disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  err,
`ifdef DISP_DIM_EN
    input  logic                  dim,
`endif
    input  logic [4*N_DIGITS-1:0] val_in,
    output logic [N_DIGITS-1:0]   dig_n,
    output logic [6:0]            seg
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [CW-1:0]       CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]       GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0]       FR_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] DIG_ONE  = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] frame_q, frame_d;
    logic                  run_q;
    disp_state_e           state_q;
    logic                  phase_q;
    logic [FW-1:0]         fcnt_q;
    logic [N_DIGITS-1:0]   dig_n_q, dig_n_d;
    logic [6:0]            seg_q, seg_d;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  in_window;
    logic                  active;
    logic [3:0]            cur_val;
    logic [6:0]            hex_seg;

    assign slot_end   = en && (cnt_q == CNT_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);

`ifdef DISP_DIM_EN
    localparam logic [CW-1:0] DIM_END = CW'(GUARD + (SCAN_DIV - GUARD) / 4);
    logic dim_q;
    logic dim_s;
    // dim is taken live on the first cycle of a slot and held for the rest of it.
    assign dim_s     = (cnt_q == '0) ? dim : dim_q;
    assign in_window = !dim_s || (cnt_q < DIM_END);

    // Hold the slot's dim decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            dim_q <= 1'b0;
        end else begin
            dim_q <= dim_s;
        end
    end
`else
    assign in_window = 1'b1;
`endif

    assign active  = en && (cnt_q >= GUARD_C) && in_window;
    assign cur_val = frame_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_dec (
        .val_i   (cur_val),
        .blank_i (!active),
        .seg_o   (hex_seg)
    );

    // Slot/digit counters and frame buffer next state. The buffer also loads on the
    // first enabled cycle so a fresh frame after reset or en=0 never shows stale data.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_wrap ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (!en || !run_q || frame_wrap) begin
            frame_d = val_in;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            run_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            run_q   <= en;
        end
    end

    // Error FSM: entry restarts the blink; exit waits for the current slot to finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            phase_q <= 1'b1;
            fcnt_q  <= '0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (err) begin
                        state_q <= ERROR;
                        phase_q <= 1'b1;
                        fcnt_q  <= '0;
                    end
                end
                default: begin
                    if (frame_wrap) begin
                        if (fcnt_q == FR_LAST) begin
                            fcnt_q  <= '0;
                            phase_q <= !phase_q;
                        end else begin
                            fcnt_q  <= fcnt_q + FW'(1);
                        end
                    end
                    if (!err && (slot_end || !en)) begin
                        state_q <= NORMAL;
                    end
                end
            endcase
        end
    end

    // Pin values for the current slot position; blank outside the active window.
    always_comb begin
        dig_n_d = '1;
        seg_d   = SEG_BLANK;
        if (active) begin
            dig_n_d = ~(DIG_ONE << idx_q);
            if (state_q == ERROR) begin
                seg_d = phase_q ? SEG_ERR : SEG_BLANK;
            end else begin
                seg_d = hex_seg;
            end
        end
    end

    // Registered pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_n_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            dig_n_q <= dig_n_d;
            seg_q   <= seg_d;
        end
    end

    assign dig_n = dig_n_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_robo_display_scan.sv
// Purpose: directed self-checking bench for robo_display_scan (N=4, SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2).
// Latency: pins are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_robo_display_scan;

    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        err;
    logic [15:0] val_in;
    logic [3:0]  dig_n;
    logic [6:0]  seg;
`ifdef DISP_DIM_EN
    logic        dim;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] gl [16];
    logic [3:0] exp_dn;
    logic [6:0] exp_seg;

    always #5 clk = ~clk;

    robo_display_scan #(
        .N_DIGITS     (4),
        .SCAN_DIV     (8),
        .GUARD        (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .err    (err),
`ifdef DISP_DIM_EN
        .dim    (dim),
`endif
        .val_in (val_in),
        .dig_n  (dig_n),
        .seg    (seg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Three reset cycles: pins at reset values.
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; err = 1'b0; val_in = 16'h1234;
`ifdef DISP_DIM_EN
        dim = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (dig_n !== 4'hF || seg !== 7'h00) begin
                n_bad++;
                $display("FAIL reset k%0d: dig_n=%b seg=%h, required 1111 00", k, dig_n, seg);
            end
        end
    endtask

    // First frame after reset: guard then 4,3,2,1.
    task automatic test_scan();
        logic [15:0] v;
        v = 16'h1234;
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                exp_dn  = (c < G) ? 4'hF : ~(4'b0001 << s);
                exp_seg = (c < G) ? 7'h00 : gl[v[4*s +: 4]];
                n_cmp++;
                if (dig_n !== exp_dn || seg !== exp_seg) begin
                    n_bad++;
                    $display("FAIL scan s%0d c%0d: dig_n=%b seg=%h, required %b %h", s, c, dig_n, seg, exp_dn, exp_seg);
                end
            end
        end
    endtask

    // val_in changes during slot 2; the frame finishes with old data, next frame shows new.
    task automatic test_frame_buffer();
        logic [15:0] v;
        for (int f = 0; f < 2; f++) begin
            v = (f == 0) ? 16'h1234 : 16'hABCD;
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 8; c++) begin
                    if (f == 0 && s == 2 && c == 0) val_in = 16'hABCD;
                    step();
                    exp_dn  = (c < G) ? 4'hF : ~(4'b0001 << s);
                    exp_seg = (c < G) ? 7'h00 : gl[v[4*s +: 4]];
                    n_cmp++;
                    if (dig_n !== exp_dn || seg !== exp_seg) begin
                        n_bad++;
                        $display("FAIL fbuf f%0d s%0d c%0d: dig_n=%b seg=%h, required %b %h", f, s, c, dig_n, seg, exp_dn, exp_seg);
                    end
                end
            end
        end
    endtask

    // en drops mid-slot: pins blank next cycle; re-enable restarts at digit 0 after guard.
    task automatic test_enable();
        logic [15:0] v;
        for (int c = 0; c < 4; c++) begin
            step();
            exp_dn  = (c < G) ? 4'hF : 4'b1110;
            exp_seg = (c < G) ? 7'h00 : 7'h5E;
            n_cmp++;
            if (dig_n !== exp_dn || seg !== exp_seg) begin
                n_bad++;
                $display("FAIL en_pre c%0d: dig_n=%b seg=%h, required %b %h", c, dig_n, seg, exp_dn, exp_seg);
            end
        end
        en = 1'b0; val_in = 16'h5678;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (dig_n !== 4'hF || seg !== 7'h00) begin
                n_bad++;
                $display("FAIL en_off k%0d: dig_n=%b seg=%h, required 1111 00", k, dig_n, seg);
            end
        end
        en = 1'b1;
        v = 16'h5678;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                exp_dn  = (c < G) ? 4'hF : ~(4'b0001 << s);
                exp_seg = (c < G) ? 7'h00 : gl[v[4*s +: 4]];
                n_cmp++;
                if (dig_n !== exp_dn || seg !== exp_seg) begin
                    n_bad++;
                    $display("FAIL en_on s%0d c%0d: dig_n=%b seg=%h, required %b %h", s, c, dig_n, seg, exp_dn, exp_seg);
                end
            end
        end
    endtask

    // err at a frame start: 2 frames of E, 2 blank, E again; release mid-slot finishes the slot with E.
    task automatic test_error_blink();
        logic [15:0] v;
        v = 16'h5678;
        err = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 8; c++) begin
                    if (f == 5 && s == 0 && c == 4) err = 1'b0;
                    step();
                    exp_dn = (c < G) ? 4'hF : ~(4'b0001 << s);
                    if (c < G)
                        exp_seg = 7'h00;
                    else if (f == 2 || f == 3)
                        exp_seg = 7'h00;
                    else if (f < 5 || s == 0)
                        exp_seg = 7'h79;
                    else
                        exp_seg = gl[v[4*s +: 4]];
                    n_cmp++;
                    if (dig_n !== exp_dn || seg !== exp_seg) begin
                        n_bad++;
                        $display("FAIL blink f%0d s%0d c%0d: dig_n=%b seg=%h, required %b %h", f, s, c, dig_n, seg, exp_dn, exp_seg);
                    end
                end
            end
        end
    endtask

    // Reset mid-frame while blinking (phase 0): reset pins at once, then E from digit 0.
    task automatic test_reset_in_error();
        err = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 8; c++) begin
                    if (!(f == 2 && (s > 1 || (s == 1 && c > 4)))) begin
                        step();
                        exp_dn  = (c < G) ? 4'hF : ~(4'b0001 << s);
                        exp_seg = (c < G || f == 2) ? 7'h00 : 7'h79;
                        n_cmp++;
                        if (dig_n !== exp_dn || seg !== exp_seg) begin
                            n_bad++;
                            $display("FAIL rerr_pre f%0d s%0d c%0d: dig_n=%b seg=%h, required %b %h", f, s, c, dig_n, seg, exp_dn, exp_seg);
                        end
                    end
                end
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (dig_n !== 4'hF || seg !== 7'h00) begin
                n_bad++;
                $display("FAIL rerr_rst k%0d: dig_n=%b seg=%h, required 1111 00", k, dig_n, seg);
            end
        end
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                exp_dn  = (c < G) ? 4'hF : ~(4'b0001 << s);
                exp_seg = (c < G) ? 7'h00 : 7'h79;
                n_cmp++;
                if (dig_n !== exp_dn || seg !== exp_seg) begin
                    n_bad++;
                    $display("FAIL rerr_post s%0d c%0d: dig_n=%b seg=%h, required %b %h", s, c, dig_n, seg, exp_dn, exp_seg);
                end
            end
        end
    endtask

`ifdef DISP_DIM_EN
    // dim = 1: guard, one active cycle, then five dark cycles per slot.
    task automatic test_dim();
        logic [15:0] v;
        v = 16'h5678;
        rst = 1'b1; err = 1'b0; dim = 1'b1;
        step();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                exp_dn  = (c == 2) ? ~(4'b0001 << s) : 4'hF;
                exp_seg = (c == 2) ? gl[v[4*s +: 4]] : 7'h00;
                n_cmp++;
                if (dig_n !== exp_dn || seg !== exp_seg) begin
                    n_bad++;
                    $display("FAIL dim s%0d c%0d: dig_n=%b seg=%h, required %b %h", s, c, dig_n, seg, exp_dn, exp_seg);
                end
            end
        end
    endtask
`endif

    initial begin
        gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        test_reset();
        test_scan();
        test_frame_buffer();
        test_enable();
        test_error_blink();
        test_reset_in_error();
`ifdef DISP_DIM_EN
        test_dim();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
